matvec_pe_sched: RTL and testbench
==================================

Name: matvec_pe_sched

Overview:
Sequencer for one multiply-accumulate PE and one shared 32-bit BRAM port. On start it computes y = M·x. It loads vector x from BRAM into a local buffer, then streams each matrix row through the PE. Each row's accumulated result is written back to BRAM, and done is raised at the end. It sits between the PS-visible BRAM and the PE, one level below the top-level controller.

Parameters:
VECTOR_SIZE, 64, elements in x and y; M is VECTOR_SIZE×VECTOR_SIZE.
L_RAM_SIZE, 6, log2 depth of the local vector buffer; 2^L_RAM_SIZE >= VECTOR_SIZE.
BRAM_RD_LAT, 2, cycles from BRAM_ADDR issue to valid BRAM_RDDATA.

Ports:
aclk  in  1  clock; also drives BRAM_CLK
aresetn  in  1  synchronous active-low reset
start  in  1  one-cycle pulse; begins a run when IDLE or DONE
done  out  1  high in DONE until next accepted start
BRAM_ADDR  out  32  byte address = word index × 4
BRAM_WRDATA  out  32  write data
BRAM_WE  out  4  byte enables; 4'hF on writes, else 0
BRAM_CLK  out  1  = aclk
BRAM_RDDATA  in  32  read data
pe_valid  out  1  operand pair valid this cycle
pe_ain  out  32  matrix element
pe_bin  out  32  vector element
pe_clear  out  1  one-cycle accumulator clear
pe_dout  in  32  PE accumulator value
pe_dvalid  in  1  one pulse per completed MAC; PE latency is arbitrary but fixed

Behaviour:
- Memory map (word index): x at 0..V-1; M row-major at V..V+V²-1; y written at V+V²..V+V²+V-1, with V = VECTOR_SIZE.
- Reset (aresetn=0 at a clock edge): state IDLE. done, BRAM_WE, pe_valid and pe_clear are 0. BRAM_ADDR, BRAM_WRDATA, pe_ain, pe_bin and all counters are 0. In-flight read tags are discarded. Reset mid-run aborts with no further writes.
- States: IDLE -> LOAD_V -> CLR -> ROW -> DRAIN -> WRITE -> (CLR if rows remain, else DONE). DONE -> CLR-path via LOAD_V on start.
- IDLE/DONE: start=1 moves to LOAD_V next cycle and drops done to 0 in the same transition. start in any other state is ignored.
- LOAD_V: issues addresses 0..V-1, one per cycle. A BRAM_RD_LAT-deep valid/index shift register tags each read. Returned data is written to vbuf[index]. Exits when the last word has been captured.
- CLR: pe_clear=1 for exactly one cycle. The MAC-done counter and row-column counter reset.
- ROW: issues address V + r·V + k for k=0..V-1, one per cycle. When a read returns (BRAM_RD_LAT cycles later), drive pe_valid=1, pe_ain=BRAM_RDDATA and pe_bin=vbuf[k_tagged] in the same cycle, registered. There are no bubbles, so a row takes V issue cycles.
- DRAIN: wait until the pe_dvalid count for the row equals V. pe_dvalid is counted in every state after CLR, including during ROW.
- WRITE: one cycle with BRAM_ADDR=(V+V²+r)×4, BRAM_WRDATA=pe_dout and BRAM_WE=4'hF. Then r increments.
- After row V-1 is written, go to DONE; done=1 on the following cycle and held.
- Reads and writes never overlap. BRAM_WE=0 in every state except WRITE.
- Counters are sized for V² + 2V word indices. No wrap within a run.

Test Plan:
- Reset for 100 cycles with start pulsed during reset -> all outputs 0, no BRAM access, state stays IDLE after release.
- V=4, behavioural integer MAC PE with latency 3, x={1,2,3,4}, M=identity -> BRAM words 20..23 = {1,2,3,4}; done rises; exactly 4 writes, each with WE=4'hF.
- V=4, x={1,1,1,1}, M rows {1,2,3,4},{0,0,0,0},{5,5,5,5},{−1,0,0,1} -> y={10,0,20,0}; pe_clear is pulsed 4 times, each before the row's first pe_valid.
- BRAM_RD_LAT=2 check -> first pe_valid of row 0 occurs exactly 2 cycles after address 4 is issued, and pe_bin=x[0].
- start pulsed mid-ROW -> ignored, result identical to the undisturbed run; start in DONE -> done falls next cycle and a second run produces identical y.
- aresetn asserted during WRITE of row 1 -> no further BRAM writes, outputs 0; after release, start completes a correct full run.

Source files
------------

// File: rtl/matvec_pe_sched.sv
// matvec_pe_sched: sequences x load, per-row MAC streaming and y write-back over one BRAM port
module matvec_pe_sched #(
  parameter int VECTOR_SIZE = 64,
  parameter int L_RAM_SIZE  = 6,
  parameter int BRAM_RD_LAT = 2
) (
  input  logic        aclk,
  input  logic        aresetn,
  input  logic        start,
  output logic        done,
  output logic [31:0] BRAM_ADDR,
  output logic [31:0] BRAM_WRDATA,
  output logic [3:0]  BRAM_WE,
  output logic        BRAM_CLK,
  input  logic [31:0] BRAM_RDDATA,
  output logic        pe_valid,
  output logic [31:0] pe_ain,
  output logic [31:0] pe_bin,
  output logic        pe_clear,
  input  logic [31:0] pe_dout,
  input  logic        pe_dvalid
);
  localparam int CW = $clog2(VECTOR_SIZE * VECTOR_SIZE + 2 * VECTOR_SIZE + 1);
  localparam logic [CW-1:0] VW = CW'(VECTOR_SIZE);
  localparam logic [CW-1:0] ONE = CW'(1);
  localparam logic [CW-1:0] YB = CW'(VECTOR_SIZE * VECTOR_SIZE + VECTOR_SIZE);
  localparam logic [L_RAM_SIZE-1:0] LAST = L_RAM_SIZE'(VECTOR_SIZE - 1);

  typedef enum logic [2:0] {IDLE, LOAD_V, CLR, ROW, DRAIN, WRITE, DONE} state_t;

  state_t state;
  logic [CW-1:0] iss_cnt, row, mac_cnt, rd_word;
  logic [BRAM_RD_LAT-1:0] rd_vld;
  logic [L_RAM_SIZE-1:0] rd_idx [BRAM_RD_LAT];
  logic [31:0] vbuf [2**L_RAM_SIZE];
  logic issue, ret, streaming;
  logic [L_RAM_SIZE-1:0] ret_idx;

  assign BRAM_CLK  = aclk;
  assign issue     = (state == LOAD_V || state == ROW) && iss_cnt < VW;
  assign rd_word   = state == ROW ? VW + row * VW + iss_cnt : iss_cnt;
  assign ret       = rd_vld[BRAM_RD_LAT-1];
  assign ret_idx   = rd_idx[BRAM_RD_LAT-1];
  assign streaming = state == ROW || state == DRAIN;

  // Read tag pipeline: marks the cycle each issued read's data is on BRAM_RDDATA
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      rd_vld <= '0;
      for (int i = 0; i < BRAM_RD_LAT; i++) rd_idx[i] <= '0;
    end else begin
      rd_vld[0] <= issue;
      rd_idx[0] <= iss_cnt[L_RAM_SIZE-1:0];
      for (int i = 1; i < BRAM_RD_LAT; i++) begin
        rd_vld[i] <= rd_vld[i-1];
        rd_idx[i] <= rd_idx[i-1];
      end
    end
  end

  // Local copy of x, filled while loading
  always_ff @(posedge aclk)
    if (state == LOAD_V && ret) vbuf[ret_idx] <= BRAM_RDDATA;

  // Control FSM with registered BRAM and PE outputs
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state       <= IDLE;
      done        <= 1'b0;
      BRAM_ADDR   <= '0;
      BRAM_WRDATA <= '0;
      BRAM_WE     <= '0;
      pe_valid    <= 1'b0;
      pe_ain      <= '0;
      pe_bin      <= '0;
      pe_clear    <= 1'b0;
      iss_cnt     <= '0;
      row         <= '0;
      mac_cnt     <= '0;
    end else begin
      BRAM_WE  <= '0;
      pe_clear <= 1'b0;
      pe_valid <= ret && streaming;
      mac_cnt  <= state == CLR ? '0 : mac_cnt + CW'(pe_dvalid);
      if (ret && streaming) begin
        pe_ain <= BRAM_RDDATA;
        pe_bin <= vbuf[ret_idx];
      end
      if (issue) begin
        BRAM_ADDR <= 32'(rd_word) << 2;
        iss_cnt   <= iss_cnt + ONE;
      end
      case (state)
        IDLE, DONE: if (start) begin
          state   <= LOAD_V;
          done    <= 1'b0;
          iss_cnt <= '0;
          row     <= '0;
        end
        LOAD_V: if (ret && ret_idx == LAST) begin
          state    <= CLR;
          pe_clear <= 1'b1;
        end
        CLR: begin
          state   <= ROW;
          iss_cnt <= '0;
        end
        ROW: if (iss_cnt == VW - ONE) state <= DRAIN;
        DRAIN: if (mac_cnt == VW) begin
          state       <= WRITE;
          BRAM_ADDR   <= 32'(YB + row) << 2;
          BRAM_WRDATA <= pe_dout;
          BRAM_WE     <= 4'hF;
        end
        WRITE: begin
          row <= row + ONE;
          if (row == VW - ONE) begin
            state <= DONE;
            done  <= 1'b1;
          end else begin
            state    <= CLR;
            pe_clear <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_matvec_pe_sched.sv
// tb_matvec_pe_sched: randomized scoreboard bench for the mat-vec scheduler
module tb_matvec_pe_sched;
  localparam int V = 4;

  logic aclk = 1'b0, aresetn = 1'b0, start = 1'b0;
  logic done, BRAM_CLK, pe_valid, pe_clear, pe_dvalid;
  logic [31:0] BRAM_ADDR, BRAM_WRDATA, BRAM_RDDATA, pe_ain, pe_bin, pe_dout;
  logic [3:0] BRAM_WE;

  typedef struct {logic [31:0] a; logic [31:0] d;} wr_t;
  wr_t wq[$];
  logic [63:0] pq[$];
  wr_t we_e;
  logic [63:0] pe_e;
  logic [31:0] mem [64];
  int xv [V];
  int mv [V][V];
  int total = 0, bad = 0, cyc = 0;
  int wr_cnt = 0, clr_cnt = 0, val_cnt = 0, addr16_cyc = -1, first_val_cyc = -1;
  logic [2:0] pv;
  logic [31:0] pp [3];
  logic [31:0] acc;

  matvec_pe_sched #(.VECTOR_SIZE(V), .L_RAM_SIZE(2), .BRAM_RD_LAT(2)) dut (
    .aclk(aclk), .aresetn(aresetn), .start(start), .done(done),
    .BRAM_ADDR(BRAM_ADDR), .BRAM_WRDATA(BRAM_WRDATA), .BRAM_WE(BRAM_WE),
    .BRAM_CLK(BRAM_CLK), .BRAM_RDDATA(BRAM_RDDATA),
    .pe_valid(pe_valid), .pe_ain(pe_ain), .pe_bin(pe_bin), .pe_clear(pe_clear),
    .pe_dout(pe_dout), .pe_dvalid(pe_dvalid)
  );

  always #5 aclk = ~aclk;

  always @(posedge aclk) cyc <= cyc + 1;

  // BRAM: address registered by the DUT, one more register here gives 2 cycles total
  always @(posedge BRAM_CLK) begin
    BRAM_RDDATA <= mem[BRAM_ADDR[7:2]];
    if (BRAM_WE == 4'hF) mem[BRAM_ADDR[7:2]] <= BRAM_WRDATA;
  end

  // Integer MAC PE with fixed pipeline latency
  always @(posedge aclk) begin
    if (!aresetn) begin
      pv <= '0;
      acc <= '0;
      pe_dvalid <= 1'b0;
    end else begin
      pv <= {pv[1:0], pe_valid};
      pp[0] <= pe_ain * pe_bin;
      pp[1] <= pp[0];
      pp[2] <= pp[1];
      pe_dvalid <= pv[2];
      if (pe_clear) acc <= '0;
      else if (pv[2]) acc <= acc + pp[2];
    end
  end
  assign pe_dout = acc;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Monitor: pops scoreboard entries whenever the DUT writes or feeds the PE
  always @(negedge aclk) begin
    if (BRAM_WE != 4'h0) begin
      wr_cnt++;
      if (wq.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_write: addr %0h data %0h", BRAM_ADDR, BRAM_WRDATA);
      end else begin
        we_e = wq.pop_front();
        check("y_addr", BRAM_ADDR, we_e.a);
        check("y_data", BRAM_WRDATA, we_e.d);
        check("y_we", 32'(BRAM_WE), 32'hF);
      end
    end
    if (pe_clear) begin
      check("clear_before_row", val_cnt, clr_cnt * V);
      clr_cnt++;
    end
    if (pe_valid) begin
      if (val_cnt == 0) first_val_cyc = cyc;
      val_cnt++;
      if (pq.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_pe_valid: ain %0h bin %0h", pe_ain, pe_bin);
      end else begin
        pe_e = pq.pop_front();
        check("pe_ain", pe_ain, pe_e[63:32]);
        check("pe_bin", pe_bin, pe_e[31:0]);
      end
    end
    if (BRAM_ADDR == 32'd16 && addr16_cyc < 0) addr16_cyc = cyc;
  end

  task automatic load_and_expect();
    wr_cnt = 0;
    clr_cnt = 0;
    val_cnt = 0;
    addr16_cyc = -1;
    first_val_cyc = -1;
    for (int i = 0; i < V; i++) mem[i] <= 32'(xv[i]);
    for (int r = 0; r < V; r++) begin
      int s;
      s = 0;
      for (int k = 0; k < V; k++) begin
        mem[V + r * V + k] <= 32'(mv[r][k]);
        s += mv[r][k] * xv[k];
        pq.push_back({32'(mv[r][k]), 32'(xv[k])});
      end
      wq.push_back('{a: 32'((V * V + V + r) * 4), d: 32'(s)});
    end
  endtask

  task automatic pulse_start();
    @(negedge aclk);
    start = 1'b1;
    @(negedge aclk);
    start = 1'b0;
  endtask

  task automatic do_run(input bit poke);
    int n;
    bit poked;
    n = 0;
    poked = 1'b0;
    load_and_expect();
    pulse_start();
    check("done_drop", 32'(done), 0);
    while (!done && n < 2000) begin
      @(negedge aclk);
      n++;
      start = poke && !poked && pe_valid;
      if (start) poked = 1'b1;
    end
    start = 1'b0;
    check("done_rise", 32'(done), 1);
    repeat (3) @(negedge aclk);
    check("done_held", 32'(done), 1);
    check("write_count", wr_cnt, V);
    check("clear_count", clr_cnt, V);
    check("rd_latency", first_val_cyc - addr16_cyc, 2);
    check("y_queue_empty", wq.size(), 0);
    check("pe_queue_empty", pq.size(), 0);
  endtask

  task automatic randomize_data();
    for (int i = 0; i < V; i++) xv[i] = int'($urandom_range(0, 40)) - 20;
    for (int r = 0; r < V; r++)
      for (int k = 0; k < V; k++) mv[r][k] = int'($urandom_range(0, 40)) - 20;
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_done"}, 32'(done), 0);
    check({tag, "_we"}, 32'(BRAM_WE), 0);
    check({tag, "_valid"}, 32'(pe_valid), 0);
    check({tag, "_clear"}, 32'(pe_clear), 0);
    check({tag, "_addr"}, BRAM_ADDR, 0);
    check({tag, "_wrdata"}, BRAM_WRDATA, 0);
    check({tag, "_ain"}, pe_ain, 0);
    check({tag, "_bin"}, pe_bin, 0);
  endtask

  initial begin
    int n;
    for (int i = 0; i < 64; i++) mem[i] <= '0;
    for (int i = 0; i < 100; i++) begin
      @(negedge aclk);
      start = (i % 7 == 3);
    end
    start = 1'b0;
    check_quiet("reset");
    aresetn = 1'b1;
    repeat (10) @(negedge aclk);
    check_quiet("idle");

    for (int i = 0; i < V; i++) xv[i] = i + 1;
    for (int r = 0; r < V; r++)
      for (int k = 0; k < V; k++) mv[r][k] = (r == k) ? 1 : 0;
    do_run(1'b0);

    xv = '{1, 1, 1, 1};
    mv = '{'{1, 2, 3, 4}, '{0, 0, 0, 0}, '{5, 5, 5, 5}, '{-1, 0, 0, 1}};
    do_run(1'b0);

    randomize_data();
    do_run(1'b1);
    do_run(1'b0);
    randomize_data();
    do_run(1'b0);

    randomize_data();
    load_and_expect();
    pulse_start();
    n = 0;
    while (!(BRAM_WE != 0 && BRAM_ADDR == 32'((V * V + V + 1) * 4)) && n < 2000) begin
      @(negedge aclk);
      n++;
    end
    check("row1_write_seen", 32'(n < 2000), 1);
    aresetn = 1'b0;
    @(posedge aclk);
    #1;
    check("aborted_rows_left", wq.size(), 2);
    wq.delete();
    pq.delete();
    repeat (5) @(negedge aclk);
    check_quiet("abort");
    aresetn = 1'b1;
    repeat (5) @(negedge aclk);
    do_run(1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
